counter_sched_arbiter: RTL and testbench
========================================

// Module: counter_sched_arbiter
// PURPOSE
//  Shares one down-counting interval timer between NUM_REQ requesters.
//  Each requester posts a length; a round-robin arbiter grants the timer and counts the job down.
//  When the job ends, the block pulses that requester's done bit.
//  Sits beside the free-running counter as the block that sequences and time-shares timing resources.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8)
//  CNT_W    8  counter/length width in bits
//  ID_W     $clog2(NUM_REQ)  grant index width (derived, not overridable)
// PORTS
//  clk        in   1              single clock; all logic on posedge
//  rst        in   1              synchronous, active-high reset
//  req_valid  in   NUM_REQ        per-requester job request
//  req_len    in   NUM_REQ*CNT_W  packed lengths; slice i = req_len[i*CNT_W +: CNT_W]
//  req_ready  out  NUM_REQ        one-hot accept; job i accepted when req_valid[i]&req_ready[i]
//  pause      in   1              1 = hold count (RUN state only)
//  flush      in   1              abort current job, no done pulse
//  done       out  NUM_REQ        one-cycle pulse to owner on completion
//  busy       out  1              1 in RUN or DONE
//  grant_id   out  ID_W           current/last owner index
//  count      out  CNT_W          remaining count
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: state=IDLE, count=0, grant_id=0, rr_ptr=0, done=0, busy=0, req_ready=0.
//    Reset mid-job aborts the job; no done pulse.
//  FSM states: IDLE, RUN, DONE.
//  IDLE:
//    - Winner w = first i with req_valid[i], searching upward from rr_ptr with wrap.
//    - req_ready = onehot(w) combinationally. Zero if no req_valid, and zero in all other states.
//    - On accept: count<=req_len[w], grant_id<=w.
//      Next state is RUN if len!=0, DONE if len==0.
//  RUN:
//    - pause=1: count holds.
//    - Else if count==1: count<=0, next state DONE.
//    - Else: count<=count-1.
//  DONE: done[grant_id]=1 for exactly one cycle; rr_ptr<=grant_id+1 (mod NUM_REQ); next state IDLE.
//  Latency: accept in cycle t with no pause -> done high in cycle t+L+1 for all L (L=0 gives t+1).
//    Next accept earliest t+L+2.
//  flush: in RUN or DONE, forces IDLE next cycle.
//    - count<=0, done suppressed (also in DONE state), rr_ptr<=grant_id+1.
//    - Ignored in IDLE.
//  Simultaneous events:
//    - flush beats count==1 and pause.
//    - pause in the count==1 cycle holds at 1.
//    - A requester dropping req_valid before grant is legal and is not latched.
//  req_len is sampled only in the accept cycle; later changes are ignored.
//  Fairness: a requester holding req_valid is granted within NUM_REQ jobs.
//  No arithmetic wrap: count never decrements below 0.
// STRUCTURE
//  Package counter_sched_pkg: state enum (IDLE/RUN/DONE), default NUM_REQ/CNT_W localparams.
//  Sub-module rr_arbiter (req, ptr -> onehot grant + index); purely combinational.
//  Top module holds the FSM, count register, rr_ptr, grant_id.
// TESTING
//  1. Single job: req_valid[0]=1, len=5 in cycle t -> req_ready[0] at t.
//     count 5,4,3,2,1 over t+1..t+5; done[0]=1 only at t+6; busy 0 at t+7.
//  2. Zero length: req_valid[2]=1, len=0 -> done[2] at t+1; count stays 0.
//  3. Round-robin: all 4 valid, len=2 each from reset -> grant order 0,1,2,3,0.
//     Each done 3 cycles after its accept.
//  4. Pause: len=4, pause=1 for 3 cycles after count=2 -> count held at 2.
//     done delayed to accept+8.
//  5. Flush: len=10, flush when count=6 -> IDLE next cycle, no done bit ever set.
//     Next grant goes to owner+1.
//  6. Reset mid-RUN: rst=1 at count=3 -> next cycle all outputs at reset values, no done.
//     Simultaneous flush with count==1 -> no done.

Source files
------------

// File: rtl/counter_sched_pkg.sv
// -----------------------------------------------------------------------------
// counter_sched_pkg
// Shared types and default sizes for the time-shared interval timer
// (counter_sched_arbiter) and its round-robin arbiter.
//   state_e      : scheduler FSM states
//   DEF_NUM_REQ  : default number of requesters
//   DEF_CNT_W    : default counter / job-length width
// -----------------------------------------------------------------------------
package counter_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_CNT_W   = 8;

endpackage : counter_sched_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the winner is the first asserted
// request found searching upward from ptr, wrapping past NUM_REQ-1 to 0.
// Ports:
//   req      in   NUM_REQ  request vector
//   ptr      in   ID_W     highest-priority index this round (< NUM_REQ)
//   gnt      out  NUM_REQ  one-hot grant, zero when no request
//   gnt_idx  out  ID_W     index of the winner (0 when no request)
//   gnt_vld  out  1        at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_vld
);

    int j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        j       = 0;
        // Scan from the farthest position back towards ptr so the last hit
        // written is the one closest to ptr, i.e. the round-robin winner.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (req[ID_W'(j)]) begin
                gnt_idx = ID_W'(j);
                gnt_vld = 1'b1;
            end
        end
        if (gnt_vld) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule : rr_arbiter

// File: rtl/counter_sched_arbiter.sv
// -----------------------------------------------------------------------------
// counter_sched_arbiter
// One down-counting interval timer shared between NUM_REQ requesters. In IDLE
// a round-robin arbiter picks a requester, its length is loaded and counted
// down in RUN, and DONE pulses the owner's done bit for one cycle. flush
// aborts a job (RUN or DONE) without a done pulse; pause holds the count.
// Ports:
//   clk        in   1              clock, all logic on posedge
//   rst        in   1              synchronous active-high reset
//   req_valid  in   NUM_REQ        per-requester job request
//   req_len    in   NUM_REQ*CNT_W  packed lengths, slice i = [i*CNT_W +: CNT_W]
//   req_ready  out  NUM_REQ        one-hot accept (IDLE only)
//   pause      in   1              hold count while in RUN
//   flush      in   1              abort job in RUN/DONE, no done pulse
//   done       out  NUM_REQ        one-cycle completion pulse to the owner
//   busy       out  1              high in RUN or DONE
//   grant_id   out  ID_W           current / last owner index
//   count      out  CNT_W          remaining count
// -----------------------------------------------------------------------------
module counter_sched_arbiter
    import counter_sched_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int CNT_W   = DEF_CNT_W,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*CNT_W-1:0]   req_len,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       pause,
    input  logic                       flush,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy,
    output logic [ID_W-1:0]            grant_id,
    output logic [CNT_W-1:0]           count
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_vld;
    logic [CNT_W-1:0]   len_arr [NUM_REQ];
    logic [CNT_W-1:0]   sel_len;
    logic [ID_W-1:0]    ptr_after_owner;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            len_arr[i] = req_len[i*CNT_W +: CNT_W];
        end
    end

    assign sel_len = len_arr[arb_idx];

    // Priority moves to the requester just after the owner once its job
    // ends, whether it completed or was flushed.
    assign ptr_after_owner = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        req_ready = '0;
        done      = '0;

        case (state_q)
            ST_IDLE: begin
                // Accept is implied whenever a winner exists: req_ready is
                // the winner's one-hot and the winner's valid is high.
                if (arb_vld && !rst) begin
                    req_ready = arb_gnt;
                    count_d   = sel_len;
                    grant_d   = arb_idx;
                    state_d   = (sel_len == '0) ? ST_DONE : ST_RUN;
                end
            end

            ST_RUN: begin
                if (flush) begin
                    count_d  = '0;
                    rr_ptr_d = ptr_after_owner;
                    state_d  = ST_IDLE;
                end else if (!pause) begin
                    if (count_q == CNT_W'(1)) begin
                        count_d = '0;
                        state_d = ST_DONE;
                    end else if (count_q != '0) begin
                        count_d = count_q - CNT_W'(1);
                    end
                end
            end

            ST_DONE: begin
                // flush in the completion cycle swallows the done pulse.
                if (!flush && !rst) begin
                    done[grant_q] = 1'b1;
                end
                count_d  = '0;
                rr_ptr_d = ptr_after_owner;
                state_d  = ST_IDLE;
            end

            default: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign busy     = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign grant_id = grant_q;
    assign count    = count_q;

endmodule : counter_sched_arbiter

// File: tb/tb_counter_sched_arbiter.sv
module tb_counter_sched_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_len;
    logic [3:0]  req_ready;
    logic        pause;
    logic        flush;
    logic [3:0]  done;
    logic        busy;
    logic [1:0]  grant_id;
    logic [7:0]  count;

    int checks   = 0;
    int failures = 0;

    counter_sched_arbiter #(
        .NUM_REQ (4),
        .CNT_W   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_len   (req_len),
        .req_ready (req_ready),
        .pause     (pause),
        .flush     (flush),
        .done      (done),
        .busy      (busy),
        .grant_id  (grant_id),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [3:0]  v;
        logic [31:0] len;
        logic        p;
        logic        f;
        logic [3:0]  rdy;
        logic [3:0]  dn;
        logic        bsy;
        logic [1:0]  gid;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic [3:0] v, input logic [31:0] len,
                       input logic p, input logic f, input logic [3:0] rdy,
                       input logic [3:0] dn, input logic bsy, input logic [1:0] gid,
                       input logic [7:0] cnt);
        vec_t e;
        e.r = r; e.v = v; e.len = len; e.p = p; e.f = f;
        e.rdy = rdy; e.dn = dn; e.bsy = bsy; e.gid = gid; e.cnt = cnt;
        vt.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [3:0] rdy, input logic [3:0] dn,
                           input logic bsy, input logic [1:0] gid, input logic [7:0] cnt);
        chk({nm, ".req_ready"}, 32'(req_ready), 32'(rdy));
        chk({nm, ".done"},      32'(done),      32'(dn));
        chk({nm, ".busy"},      32'(busy),      32'(bsy));
        chk({nm, ".grant_id"},  32'(grant_id),  32'(gid));
        chk({nm, ".count"},     32'(count),     32'(cnt));
    endtask

    // Drive one cycle's inputs just after the edge, then wait for the
    // opposite edge so outputs are sampled mid-cycle.
    task automatic cyc(input logic r, input logic [3:0] v, input logic [31:0] len,
                       input logic p, input logic f);
        @(posedge clk);
        #1;
        rst = r; req_valid = v; req_len = len; pause = p; flush = f;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_len = '0; pause = 1'b0; flush = 1'b0;

        // ---------------- vector table ----------------
        // Single job, lane 0 len 5; len changes after accept are ignored.
        add(0, 4'b0001, 32'h00000005, 0, 0, 4'b0001, 4'b0000, 0, 0, 8'd0);
        add(0, 4'b0000, 32'h000000FF, 0, 0, 4'b0000, 4'b0000, 1, 0, 8'd5);
        add(0, 4'b0000, 32'h000000FF, 0, 0, 4'b0000, 4'b0000, 1, 0, 8'd4);
        add(0, 4'b0000, 32'h000000FF, 0, 0, 4'b0000, 4'b0000, 1, 0, 8'd3);
        add(0, 4'b0000, 32'h000000FF, 0, 0, 4'b0000, 4'b0000, 1, 0, 8'd2);
        add(0, 4'b0000, 32'h000000FF, 0, 0, 4'b0000, 4'b0000, 1, 0, 8'd1);
        add(0, 4'b0000, 32'h00000000, 0, 0, 4'b0000, 4'b0001, 1, 0, 8'd0);
        add(0, 4'b0000, 32'h00000000, 0, 0, 4'b0000, 4'b0000, 0, 0, 8'd0);
        // Zero length on lane 2, other lanes non-zero.
        add(0, 4'b0100, 32'h07000903, 0, 0, 4'b0100, 4'b0000, 0, 0, 8'd0);
        add(0, 4'b0000, 32'h00000000, 0, 0, 4'b0000, 4'b0100, 1, 2, 8'd0);
        add(0, 4'b0000, 32'h00000000, 0, 0, 4'b0000, 4'b0000, 0, 2, 8'd0);
        // Reset, then all four requesting len 2 -> order 0,1,2,3,0.
        add(1, 4'b0000, 32'h00000000, 0, 0, 4'b0000, 4'b0000, 0, 2, 8'd0);
        for (int k = 0; k < 4; k++) begin
            add(0, 4'b1111, 32'h02020202, 0, 0, 4'(1 << k), 4'b0000, 0, 2'(k == 0 ? 0 : k - 1), 8'd0);
            add(0, 4'b1111, 32'h02020202, 0, 0, 4'b0000, 4'b0000, 1, 2'(k), 8'd2);
            add(0, 4'b1111, 32'h02020202, 0, 0, 4'b0000, 4'b0000, 1, 2'(k), 8'd1);
            add(0, 4'b1111, 32'h02020202, 0, 0, 4'b0000, 4'(1 << k), 1, 2'(k), 8'd0);
        end
        add(0, 4'b1111, 32'h02020202, 0, 0, 4'b0001, 4'b0000, 0, 3, 8'd0);
        add(0, 4'b0000, 32'h00000000, 0, 0, 4'b0000, 4'b0000, 1, 0, 8'd2);
        add(0, 4'b0000, 32'h00000000, 0, 0, 4'b0000, 4'b0000, 1, 0, 8'd1);
        add(0, 4'b0000, 32'h00000000, 0, 0, 4'b0000, 4'b0001, 1, 0, 8'd0);
        add(0, 4'b0000, 32'h00000000, 0, 0, 4'b0000, 4'b0000, 0, 0, 8'd0);

        // ---------------- reset ----------------
        cyc(1, 4'b0000, 32'h0, 0, 0);
        cyc(1, 4'b0000, 32'h0, 0, 0);
        chk_all("reset", 4'b0000, 4'b0000, 0, 0, 8'd0);

        for (int i = 0; i < vt.size(); i++) begin
            cyc(vt[i].r, vt[i].v, vt[i].len, vt[i].p, vt[i].f);
            chk_all($sformatf("vec%0d", i), vt[i].rdy, vt[i].dn, vt[i].bsy, vt[i].gid, vt[i].cnt);
        end

        // ---------------- pause: lane 1 len 4, hold 3 cycles at 2 ----------------
        begin
            logic [7:0] exp_cnt [10];
            exp_cnt = '{8'd0, 8'd4, 8'd3, 8'd2, 8'd2, 8'd2, 8'd2, 8'd1, 8'd0, 8'd0};
            cyc(0, 4'b0010, 32'h00000400, 0, 0);
            chk("pause.accept", 32'(req_ready), 32'b0010);
            for (int k = 1; k <= 9; k++) begin
                cyc(0, 4'b0000, 32'h0, (k >= 3 && k <= 5), 0);
                chk($sformatf("pause.count%0d", k), 32'(count), 32'(exp_cnt[k]));
                chk($sformatf("pause.done%0d", k), 32'(done), (k == 8) ? 32'b0010 : 32'b0);
            end
            chk("pause.idle_busy", 32'(busy), 32'd0);
        end

        // ---------------- pause in the count==1 cycle: lane 2 len 1 ----------------
        cyc(0, 4'b0100, 32'h00010000, 0, 0);
        chk("p1.accept", 32'(req_ready), 32'b0100);
        cyc(0, 4'b0000, 32'h0, 1, 0);
        chk("p1.cnt1a", 32'(count), 32'd1);
        cyc(0, 4'b0000, 32'h0, 1, 0);
        chk("p1.cnt1b", 32'(count), 32'd1);
        chk("p1.nodone", 32'(done), 32'd0);
        cyc(0, 4'b0000, 32'h0, 0, 0);
        chk("p1.cnt1c", 32'(count), 32'd1);
        cyc(0, 4'b0000, 32'h0, 0, 0);
        chk_all("p1.done", 4'b0000, 4'b0100, 1, 2, 8'd0);

        // ---------------- flush at count 6, then reset mid-RUN ----------------
        cyc(0, 4'b1000, 32'h0A000000, 0, 0);
        chk("fl.accept", 32'(req_ready), 32'b1000);
        for (int k = 1; k <= 5; k++) begin
            cyc(0, 4'b0000, 32'h0, 0, (k == 5));
            chk($sformatf("fl.count%0d", k), 32'(count), 32'(11 - k));
            chk($sformatf("fl.done%0d", k), 32'(done), 32'd0);
        end
        // Owner was 3, so priority now starts at 0 even with 3 requesting.
        cyc(0, 4'b1001, 32'h0A000005, 0, 0);
        chk_all("fl.after", 4'b0001, 4'b0000, 0, 3, 8'd0);
        cyc(0, 4'b0000, 32'h0, 0, 0);
        chk_all("rs.run5", 4'b0000, 4'b0000, 1, 0, 8'd5);
        cyc(0, 4'b0000, 32'h0, 0, 0);
        chk("rs.run4", 32'(count), 32'd4);
        cyc(1, 4'b0000, 32'h0, 0, 0);
        chk("rs.run3", 32'(count), 32'd3);
        cyc(0, 4'b0000, 32'h0, 0, 0);
        chk_all("rs.after", 4'b0000, 4'b0000, 0, 0, 8'd0);
        cyc(0, 4'b0000, 32'h0, 0, 0);
        chk_all("rs.after2", 4'b0000, 4'b0000, 0, 0, 8'd0);

        // ---------------- flush with count==1, flush in DONE ----------------
        cyc(0, 4'b0001, 32'h00000002, 0, 0);
        chk("fc.accept", 32'(req_ready), 32'b0001);
        cyc(0, 4'b0000, 32'h0, 0, 0);
        chk("fc.cnt2", 32'(count), 32'd2);
        cyc(0, 4'b0000, 32'h0, 0, 1);
        chk_all("fc.cnt1", 4'b0000, 4'b0000, 1, 0, 8'd1);
        cyc(0, 4'b0011, 32'h00000002, 0, 0);
        chk_all("fc.idle", 4'b0010, 4'b0000, 0, 0, 8'd0);
        cyc(0, 4'b0000, 32'h0, 0, 1);
        chk_all("fd.done_flushed", 4'b0000, 4'b0000, 1, 1, 8'd0);
        cyc(0, 4'b0101, 32'h00000002, 0, 0);
        chk_all("fd.next", 4'b0100, 4'b0000, 0, 1, 8'd0);
        cyc(0, 4'b0000, 32'h0, 0, 0);
        chk_all("fd.done2", 4'b0000, 4'b0100, 1, 2, 8'd0);
        cyc(0, 4'b0000, 32'h0, 0, 0);
        chk_all("fd.idle", 4'b0000, 4'b0000, 0, 2, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_counter_sched_arbiter
